// File: rtl/long_division_types_pkg.sv
// Shared types and constants for the stream long divider.
// LONG_DIVISION_ROUND_EN (when defined) enables round-half-up quotients.
package long_division_types_pkg;

  typedef enum logic [1:0] {
    IDLE_E,
    WAIT_DIVISOR_E,
    DIVIDE_E,
    OUTPUT_E
  } long_div_state_t;

  // One quotient bit per iteration; rounding needs one guard bit beyond the LSB.
  function automatic int div_iters(input int n_bits, input int q_bits, input bit round_en);
    return n_bits + q_bits + (round_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/long_division_core.sv
// Iterative restoring divider: (dividend << Q) / divisor, one quotient bit per clock.
// LONG_DIVISION_ROUND_EN adds a guard iteration and rounds half up.
module long_division_core
  import long_division_types_pkg::*;
#(
  parameter int N_BITS_P = 32,
  parameter int Q_BITS_P = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [N_BITS_P-1:0] dividend_i,
  input  logic [N_BITS_P-1:0] divisor_i,
  output logic                done_o,
  output logic [N_BITS_P-1:0] quotient_o,
  output logic                overflow_o
);

`ifdef LONG_DIVISION_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif
  localparam int ITERS = div_iters(N_BITS_P, Q_BITS_P, ROUND_EN);
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam int SHIFT = ITERS - N_BITS_P;

  logic [N_BITS_P:0]   rem_q, rem_d;
  logic [ITERS-1:0]    quo_q, quo_d;
  logic [N_BITS_P-1:0] div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic [N_BITS_P:0]   trial;
  logic [N_BITS_P:0]   diff;
  logic                ge;

  // quo_q starts as the shifted numerator and fills with quotient bits from the right.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    trial  = {rem_q[N_BITS_P-1:0], quo_q[ITERS-1]};
    diff   = trial - {1'b0, div_q};
    ge     = rem_q[N_BITS_P] | (trial >= {1'b0, div_q});
    if (start_i) begin
      rem_d  = '0;
      quo_d  = {{SHIFT{1'b0}}, dividend_i} << SHIFT;
      div_d  = divisor_i;
      cnt_d  = CNT_W'(ITERS);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? diff : trial;
      quo_d = {quo_q[ITERS-2:0], ge};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_W'(1));

`ifdef LONG_DIVISION_ROUND_EN
  logic [N_BITS_P:0] rounded;
  always_comb begin
    rounded    = {1'b0, quo_d[N_BITS_P:1]} + {{N_BITS_P{1'b0}}, quo_d[0]};
    overflow_o = (|quo_d[ITERS-1:N_BITS_P+1]) | rounded[N_BITS_P];
    quotient_o = overflow_o ? {N_BITS_P{1'b1}} : rounded[N_BITS_P-1:0];
  end
`else
  always_comb begin
    overflow_o = |quo_d[ITERS-1:N_BITS_P];
    quotient_o = overflow_o ? {N_BITS_P{1'b1}} : quo_d[N_BITS_P-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    div_q <= div_d;
  end

endmodule

// File: rtl/long_division_axi4s.sv
// Stream wrapper: dividend beat, divisor beat (tlast=1), one quotient beat out.
// LONG_DIVISION_ROUND_EN (when defined) selects round-half-up in the core.
module long_division_axi4s
  import long_division_types_pkg::*;
#(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ID_WIDTH_P   = 2,
  parameter int N_BITS_P         = 32,
  parameter int Q_BITS_P         = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ing_tvalid,
  output logic                        ing_tready,
  input  logic [AXI_DATA_WIDTH_P-1:0] ing_tdata,
  input  logic                        ing_tlast,
  input  logic [AXI_ID_WIDTH_P-1:0]   ing_tid,
  output logic                        egr_tvalid,
  input  logic                        egr_tready,
  output logic [AXI_DATA_WIDTH_P-1:0] egr_tdata,
  output logic                        egr_tlast,
  output logic [AXI_ID_WIDTH_P-1:0]   egr_tid,
  output logic                        egr_tuser
);

  long_div_state_t             state_q;
  logic                        ing_tready_q;
  logic                        egr_tvalid_q;
  logic                        egr_tlast_q;
  logic                        egr_tuser_q;
  logic [AXI_DATA_WIDTH_P-1:0] egr_tdata_q;
  logic [AXI_ID_WIDTH_P-1:0]   egr_tid_q;
  logic [N_BITS_P-1:0]         dividend_q;
  logic [AXI_ID_WIDTH_P-1:0]   tid_q;

  logic                        ing_hs;
  logic [N_BITS_P-1:0]         operand;
  logic                        div_start;
  logic                        div_done;
  logic                        div_ovf;
  logic [N_BITS_P-1:0]         div_quot;

  assign ing_hs    = ing_tvalid & ing_tready_q;
  assign operand   = ing_tdata[N_BITS_P-1:0];
  assign div_start = (state_q == WAIT_DIVISOR_E) && ing_hs && ing_tlast && (operand != '0);

  long_division_core #(
    .N_BITS_P (N_BITS_P),
    .Q_BITS_P (Q_BITS_P)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (dividend_q),
    .divisor_i  (operand),
    .done_o     (div_done),
    .quotient_o (div_quot),
    .overflow_o (div_ovf)
  );

  // Operand capture; ready is low outside IDLE/WAIT so handshakes only land there.
  always_ff @(posedge clk) begin
    if (ing_hs && !ing_tlast) begin
      dividend_q <= operand;
    end
    if (div_start) begin
      tid_q <= ing_tid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE_E;
      ing_tready_q <= 1'b0;
      egr_tvalid_q <= 1'b0;
      egr_tlast_q  <= 1'b0;
      egr_tuser_q  <= 1'b0;
      egr_tdata_q  <= '0;
      egr_tid_q    <= '0;
    end else begin
      case (state_q)
        IDLE_E: begin
          ing_tready_q <= 1'b1;
          if (ing_hs && !ing_tlast) begin
            state_q <= WAIT_DIVISOR_E;
          end
        end
        WAIT_DIVISOR_E: begin
          ing_tready_q <= 1'b1;
          if (ing_hs && ing_tlast) begin
            ing_tready_q <= 1'b0;
            if (operand == '0) begin
              state_q      <= OUTPUT_E;
              egr_tvalid_q <= 1'b1;
              egr_tlast_q  <= 1'b1;
              egr_tuser_q  <= 1'b1;
              egr_tdata_q  <= AXI_DATA_WIDTH_P'({N_BITS_P{1'b1}});
              egr_tid_q    <= ing_tid;
            end else begin
              state_q <= DIVIDE_E;
            end
          end
        end
        DIVIDE_E: begin
          ing_tready_q <= 1'b0;
          if (div_done) begin
            state_q      <= OUTPUT_E;
            egr_tvalid_q <= 1'b1;
            egr_tlast_q  <= 1'b1;
            egr_tuser_q  <= div_ovf;
            egr_tdata_q  <= AXI_DATA_WIDTH_P'(div_quot);
            egr_tid_q    <= tid_q;
          end
        end
        OUTPUT_E: begin
          if (egr_tready) begin
            state_q      <= IDLE_E;
            egr_tvalid_q <= 1'b0;
            egr_tlast_q  <= 1'b0;
            ing_tready_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE_E;
          ing_tready_q <= 1'b0;
          egr_tvalid_q <= 1'b0;
          egr_tlast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ing_tready = ing_tready_q;
  assign egr_tvalid = egr_tvalid_q;
  assign egr_tlast  = egr_tlast_q;
  assign egr_tuser  = egr_tuser_q;
  assign egr_tdata  = egr_tdata_q;
  assign egr_tid    = egr_tid_q;

endmodule

// File: tb/tb_long_division_axi4s.sv
// Bench for long_division_axi4s: cycle-level reference model plus directed literal cases.
module tb_long_division_axi4s;

  localparam int DW = 32;
  localparam int IW = 2;
  localparam int N  = 32;
  localparam int Q  = 11;
`ifdef LONG_DIVISION_ROUND_EN
  localparam bit RND = 1'b1;
  localparam int LAT = N + Q + 2;
`else
  localparam bit RND = 1'b0;
  localparam int LAT = N + Q + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ing_tvalid = 1'b0;
  logic          ing_tready;
  logic [DW-1:0] ing_tdata = '0;
  logic          ing_tlast = 1'b0;
  logic [IW-1:0] ing_tid = '0;
  logic          egr_tvalid;
  logic          egr_tready = 1'b1;
  logic [DW-1:0] egr_tdata;
  logic          egr_tlast;
  logic [IW-1:0] egr_tid;
  logic          egr_tuser;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  long_division_axi4s #(
    .AXI_DATA_WIDTH_P (DW),
    .AXI_ID_WIDTH_P   (IW),
    .N_BITS_P         (N),
    .Q_BITS_P         (Q)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ing_tvalid (ing_tvalid),
    .ing_tready (ing_tready),
    .ing_tdata  (ing_tdata),
    .ing_tlast  (ing_tlast),
    .ing_tid    (ing_tid),
    .egr_tvalid (egr_tvalid),
    .egr_tready (egr_tready),
    .egr_tdata  (egr_tdata),
    .egr_tlast  (egr_tlast),
    .egr_tid    (egr_tid),
    .egr_tuser  (egr_tuser)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference quotient straight from the arithmetic definition.
  function automatic void ref_div(input longint unsigned dvd, input longint unsigned dvs,
                                  output logic [31:0] d, output logic u);
    longint unsigned q;
    if (dvs == 0) begin
      d = 32'hFFFF_FFFF;
      u = 1'b1;
    end else begin
      if (RND) begin
        q = (dvd << (Q + 1)) / dvs;
        q = (q >> 1) + (q & 64'd1);
      end else begin
        q = (dvd << Q) / dvs;
      end
      if (q >= (64'd1 << N)) begin
        d = 32'hFFFF_FFFF;
        u = 1'b1;
      end else begin
        d = q[31:0];
        u = 1'b0;
      end
    end
  endfunction

  logic          m_rdy = 1'b0;
  logic          m_vld = 1'b0;
  logic          m_user = 1'b0;
  logic [31:0]   m_data = '0;
  logic [IW-1:0] m_tid = '0;
  logic          m_have = 1'b0;
  logic [31:0]   m_dvd = '0;
  int            m_busy = 0;
  logic [31:0]   p_data;
  logic          p_user;
  logic [IW-1:0] p_tid;

  // Compare mid-cycle, then advance the model with the inputs the next edge will see.
  initial forever begin
    @(negedge clk);
    chk("ing_tready", ing_tready, m_rdy);
    chk("egr_tvalid", egr_tvalid, m_vld);
    chk("egr_tlast", egr_tlast, m_vld);
    if (m_vld) begin
      chk("egr_tdata", egr_tdata, m_data);
      chk("egr_tid", egr_tid, m_tid);
      chk("egr_tuser", egr_tuser, m_user);
    end
    if (!rst_n) begin
      m_rdy = 0; m_vld = 0; m_user = 0; m_data = '0; m_tid = '0; m_have = 0; m_busy = 0;
    end else if (m_vld) begin
      if (egr_tready) begin
        m_vld = 0;
        m_rdy = 1;
      end
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
      if (m_busy == 0) begin
        m_vld = 1; m_data = p_data; m_user = p_user; m_tid = p_tid;
      end
    end else if (!m_rdy) begin
      m_rdy = 1;
    end else if (ing_tvalid) begin
      if (!ing_tlast) begin
        m_dvd = ing_tdata;
        m_have = 1;
      end else if (m_have) begin
        m_have = 0;
        m_rdy = 0;
        ref_div(longint'(m_dvd), longint'(ing_tdata), p_data, p_user);
        p_tid = ing_tid;
        if (ing_tdata == 0) begin
          m_vld = 1; m_data = p_data; m_user = p_user; m_tid = p_tid;
        end else begin
          m_busy = LAT - 1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit last, input logic [IW-1:0] id, input int gap);
    bit hs;
    bit ok = 0;
    repeat (gap) begin @(posedge clk); #1; end
    ing_tvalid = 1; ing_tdata = d; ing_tlast = last; ing_tid = id;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      hs = ing_tready;
      @(posedge clk); #1;
      if (hs) begin ok = 1; break; end
    end
    ing_tvalid = 0; ing_tlast = 0;
    acc_cyc = cyc;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_vld(output int lat, output logic [31:0] d, output logic [IW-1:0] id, output logic u);
    bit got = 0;
    lat = -1; d = '0; id = '0; u = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (egr_tvalid) begin
        lat = cyc - acc_cyc + 1; d = egr_tdata; id = egr_tid; u = egr_tuser;
        got = 1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!got) chk("vld_timeout", 0, 1);
  endtask

  task automatic drain_rand();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (egr_tvalid && egr_tready) done = 1;
      @(posedge clk); #1;
      egr_tready = ($urandom_range(0, 2) != 0);
    end
    if (!done) chk("drain_timeout", 0, 1);
    egr_tready = 1;
  endtask

  task automatic no_beat(input string nm, input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen = seen | egr_tvalid;
    end
    @(posedge clk); #1;
    chk(nm, seen, 0);
  endtask

  initial begin
    int lat;
    logic [31:0] d, hd;
    logic [IW-1:0] id, hid;
    logic u, hu;
    logic [31:0] dvd, dvs;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ing_tready", ing_tready, 0);
    chk("rst_egr_tvalid", egr_tvalid, 0);
    chk("rst_egr_tdata", egr_tdata, 0);
    chk("rst_egr_tlast", egr_tlast, 0);
    chk("rst_egr_tid", egr_tid, 0);
    chk("rst_egr_tuser", egr_tuser, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_rst", ing_tready, 1);

    send(32'd12288, 0, 2'd0, 0);
    send(32'd6144, 1, 2'd2, 0);
    wait_vld(lat, d, id, u);
    chk("six_by_three_lat", lat, LAT);
    chk("six_by_three_data", d, 4096);
    chk("six_by_three_user", u, 0);
    chk("six_by_three_tid", id, 2);

    send(32'd1, 0, 2'd0, 1);
    send(32'd3, 1, 2'd0, 0);
    wait_vld(lat, d, id, u);
    chk("third_data", d, RND ? 683 : 682);
    chk("third_lat", lat, LAT);

    send(32'd5, 0, 2'd0, 0);
    send(32'd0, 1, 2'd1, 0);
    wait_vld(lat, d, id, u);
    chk("dbz_lat", lat, 1);
    chk("dbz_data", d, 32'hFFFF_FFFF);
    chk("dbz_user", u, 1);
    chk("dbz_tid", id, 1);

    send(32'h7FFF_FFFF, 0, 2'd0, 0);
    send(32'd1, 1, 2'd3, 0);
    wait_vld(lat, d, id, u);
    chk("ovf_data", d, 32'hFFFF_FFFF);
    chk("ovf_user", u, 1);

    egr_tready = 0;
    send(32'd100, 0, 2'd0, 0);
    send(32'd7, 1, 2'd3, 0);
    wait_vld(lat, hd, hid, hu);
    chk("hold_data", hd, 29257);
    chk("hold_tid", hid, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_vld", egr_tvalid, 1);
      chk("hold_stable_data", egr_tdata, hd);
      chk("hold_stable_tid", egr_tid, hid);
      chk("hold_stable_user", egr_tuser, hu);
      chk("hold_ing_tready", ing_tready, 0);
    end
    @(posedge clk); #1;
    egr_tready = 1;
    @(negedge clk);
    chk("hs_vld_before", egr_tvalid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hs_vld_after", egr_tvalid, 0);
    chk("hs_ready_after", ing_tready, 1);
    @(posedge clk); #1;
    send(32'd12288, 0, 2'd0, 0);
    send(32'd6144, 1, 2'd1, 0);
    wait_vld(lat, d, id, u);
    chk("after_hold_data", d, 4096);

    send(32'd55, 1, 2'd1, 0);
    no_beat("drop_tlast_idle", 50);
    send(32'd9, 0, 2'd0, 0);
    send(32'd3, 1, 2'd2, 0);
    wait_vld(lat, d, id, u);
    chk("after_drop_data", d, 6144);

    send(32'd1000, 0, 2'd0, 0);
    send(32'd10, 1, 2'd1, 0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("midrst_ing_tready", ing_tready, 0);
    chk("midrst_egr_tvalid", egr_tvalid, 0);
    chk("midrst_egr_tdata", egr_tdata, 0);
    chk("midrst_egr_tuser", egr_tuser, 0);
    chk("midrst_egr_tid", egr_tid, 0);
    no_beat("no_beat_after_rst", 60);
    send(32'd1, 0, 2'd0, 0);
    send(32'd3, 1, 2'd1, 0);
    wait_vld(lat, d, id, u);
    chk("post_rst_data", d, RND ? 683 : 682);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: dvd = $urandom;
        1: dvd = $urandom & 32'hFFFF;
        2: dvd = $urandom_range(0, 20);
        default: dvd = $urandom >> $urandom_range(0, 31);
      endcase
      case ($urandom_range(0, 7))
        0: dvs = 0;
        1, 2: dvs = $urandom;
        3, 4: dvs = $urandom_range(1, 1000);
        default: dvs = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 5) == 0) send($urandom, 1, 2'($urandom), $urandom_range(0, 2));
      send(dvd, 0, 2'd0, $urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) begin
        dvd = $urandom;
        send(dvd, 0, 2'd0, $urandom_range(0, 2));
      end
      send(dvs, 1, 2'($urandom), $urandom_range(0, 2));
      drain_rand();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
